uart_rx: RTL and testbench

Serial receive front end for the debug packet engine. It oversamples the rs-232 rx line at 16x baud and deframes start, data, parity and stop bits. Good bytes are stored in a show-ahead FIFO. The debug controller pops bytes using rx_empty, rx_data and rd_en, and collects error pulses into its sticky error code.

---
 rtl/uart_rx.sv | 133 +++++++++++++
 tb/tb_uart_rx.sv | 135 +++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling UART receiver with odd/even parity, framing/overflow error pulses and a show-ahead FIFO
module uart_rx #(
  parameter int SYS_CLK_FREQ = 50000000,
  parameter int BAUD_RATE = 19200,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY_MODE = 1,
  parameter int FIFO_ADDR_BITS = 3
) (
  input logic clk,
  input logic rst,
  input logic rx,
  input logic rd_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic rx_empty,
  output logic rx_full,
  output logic parity_err,
  output logic framing_err,
  output logic overflow_err
);
  localparam int DIV = (SYS_CLK_FREQ + BAUD_RATE * 8) / (BAUD_RATE * 16);
  localparam int CW = $clog2(DIV + 1);
  localparam int AW = FIFO_ADDR_BITS;
  localparam int DEPTH = 1 << AW;
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
  logic s1_q, s2_q, prev_q, rxs;
  logic [CW-1:0] div_q, div_d;
  logic [2:0] state_q, state_d, bcnt_q, bcnt_d;
  logic [3:0] tcnt_q, tcnt_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic pe_q, pe_d, fe_q, fe_d, fe_now;
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic perr_q, perr_d, ferr_q, ferr_d, oerr_q, oerr_d;
  logic start, tick, samp, done, push, pop, wr;
  always_comb begin
    rxs = s2_q;
    start = state_q == IDLE && prev_q && !rxs;
    tick = div_q == CW'(DIV - 1);
    div_d = (start || tick) ? '0 : div_q + 1'b1;
    samp = tick && tcnt_q == (state_q == START ? 4'd7 : 4'd15);
    done = samp && state_q == STOP && bcnt_q == 3'(STOP_BITS - 1);
    fe_now = fe_q | !rxs;
    push = done && !fe_now && !pe_q;
    rx_empty = cnt_q == '0;
    rx_full = cnt_q == (AW + 1)'(DEPTH);
    pop = rd_en && !rx_empty;
    wr = push && (!rx_full || pop);
    wp_d = wp_q + AW'(wr);
    rp_d = rp_q + AW'(pop);
    cnt_d = cnt_q + (AW + 1)'(wr) - (AW + 1)'(pop);
    ferr_d = done && fe_now;
    perr_d = done && !fe_now && pe_q;
    oerr_d = push && rx_full && !pop;
    rx_data = mem_q[rp_q];
    parity_err = perr_q;
    framing_err = ferr_q;
    overflow_err = oerr_q;
  end
  always_comb begin
    state_d = state_q;
    bcnt_d = bcnt_q;
    sh_d = sh_q;
    pe_d = pe_q;
    fe_d = fe_q;
    tcnt_d = (start || samp) ? '0 : tcnt_q + {3'b0, tick};
    case (state_q)
      IDLE: if (start) begin
        state_d = START;
        bcnt_d = '0;
        pe_d = 1'b0;
        fe_d = 1'b0;
      end
      START: if (samp) state_d = rxs ? IDLE : DATA;
      DATA: if (samp) begin
        sh_d = {rxs, sh_q[DATA_BITS-1:1]};
        bcnt_d = bcnt_q == 3'(DATA_BITS - 1) ? '0 : bcnt_q + 3'd1;
        state_d = bcnt_q != 3'(DATA_BITS - 1) ? DATA : PARITY_MODE == 0 ? STOP : PARITY;
      end
      PARITY: if (samp) begin
        pe_d = (^{sh_q, rxs}) == (PARITY_MODE == 2);
        state_d = STOP;
      end
      STOP: if (samp) begin
        fe_d = fe_now;
        bcnt_d = bcnt_q + 3'd1;
        state_d = done ? IDLE : STOP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      prev_q <= 1'b0;
      div_q <= '0;
      state_q <= IDLE;
      bcnt_q <= '0;
      tcnt_q <= '0;
      sh_q <= '0;
      pe_q <= 1'b0;
      fe_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      oerr_q <= 1'b0;
    end else begin
      s1_q <= rx;
      s2_q <= s1_q;
      prev_q <= rxs;
      div_q <= div_d;
      state_q <= state_d;
      bcnt_q <= bcnt_d;
      tcnt_q <= tcnt_d;
      sh_q <= sh_d;
      pe_q <= pe_d;
      fe_q <= fe_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      oerr_q <= oerr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr && !rst) mem_q[wp_q] <= sh_q;
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frame table plus hand sequences for false start, overflow and mid-frame reset
module tb_uart_rx;
  localparam int F = 1500000;
  localparam int B = 19200;
  localparam int DIV = 5;
  localparam int BIT = 16 * DIV;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, rd_en = 1'b0;
  logic [7:0] rx_data;
  logic rx_empty, rx_full, parity_err, framing_err, overflow_err;
  uart_rx #(.SYS_CLK_FREQ(F), .BAUD_RATE(B), .DATA_BITS(8), .STOP_BITS(1), .PARITY_MODE(1), .FIFO_ADDR_BITS(3)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en), .rx_data(rx_data), .rx_empty(rx_empty),
    .rx_full(rx_full), .parity_err(parity_err), .framing_err(framing_err), .overflow_err(overflow_err)
  );
  always #5 clk = ~clk;
  int cyc = 0, n_pe = 0, n_fe = 0, n_oe = 0, fall_cyc = -1;
  int checks = 0, errors = 0;
  logic last_empty = 1'b1;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    n_pe = n_pe + int'(parity_err);
    n_fe = n_fe + int'(framing_err);
    n_oe = n_oe + int'(overflow_err);
    if (last_empty && !rx_empty && fall_cyc < 0) fall_cyc = cyc;
    last_empty = rx_empty;
  end
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] d, input logic par_ok, input logic stop);
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(d[i], BIT);
    hold(par_ok ? ~^d : ^d, BIT);
    hold(stop, BIT);
    hold(1'b1, BIT);
  endtask
  task automatic pop();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask
  typedef struct {
    logic [7:0] d;
    logic par_ok;
    logic stop;
    logic store;
    int pe;
    int fe;
  } vec_t;
  vec_t tab[6];
  int pe0, fe0, oe0, start_cyc;
  initial begin
    tab[0] = '{8'h55, 1'b1, 1'b1, 1'b1, 0, 0};
    tab[1] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1, 0};
    tab[2] = '{8'h12, 1'b1, 1'b0, 1'b0, 0, 1};
    tab[3] = '{8'h34, 1'b1, 1'b1, 1'b1, 0, 0};
    tab[4] = '{8'hC3, 1'b0, 1'b0, 1'b0, 0, 1};
    tab[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 0, 0};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_empty", int'(rx_empty), 1);
    chk("reset_full", int'(rx_full), 0);
    chk("reset_errs", int'({parity_err, framing_err, overflow_err}), 0);
    start_cyc = cyc;
    for (int i = 0; i < 6; i++) begin
      pe0 = n_pe;
      fe0 = n_fe;
      send(tab[i].d, tab[i].par_ok, tab[i].stop);
      chk($sformatf("v%0d_perr", i), n_pe - pe0, tab[i].pe);
      chk($sformatf("v%0d_ferr", i), n_fe - fe0, tab[i].fe);
      chk($sformatf("v%0d_empty", i), int'(rx_empty), int'(!tab[i].store));
      if (tab[i].store) begin
        chk($sformatf("v%0d_data", i), int'(rx_data), int'(tab[i].d));
        pop();
        chk($sformatf("v%0d_pop_empty", i), int'(rx_empty), 1);
      end
    end
    chk("push_latency", fall_cyc - start_cyc, 3 + DIV * 168);
    pe0 = n_pe;
    fe0 = n_fe;
    hold(1'b0, 4 * DIV);
    hold(1'b1, 2 * BIT);
    chk("false_start_empty", int'(rx_empty), 1);
    chk("false_start_errs", n_pe - pe0 + n_fe - fe0, 0);
    send(8'h3C, 1'b1, 1'b1);
    chk("after_false_data", int'(rx_data), 8'h3C);
    chk("after_false_empty", int'(rx_empty), 0);
    pop();
    oe0 = n_oe;
    for (int i = 0; i < 9; i++) begin
      send(8'(i), 1'b1, 1'b1);
      if (i == 6) chk("full_at_7", int'(rx_full), 0);
      if (i == 7) chk("full_at_8", int'(rx_full), 1);
    end
    chk("overflow_pulse", n_oe - oe0, 1);
    chk("full_after_ovf", int'(rx_full), 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_%0d", i), int'(rx_data), i);
      pop();
    end
    chk("drain_empty", int'(rx_empty), 1);
    chk("drain_full", int'(rx_full), 0);
    send(8'h01, 1'b1, 1'b1);
    send(8'h02, 1'b1, 1'b1);
    send(8'h03, 1'b1, 1'b1);
    chk("queued_head", int'(rx_data), 8'h01);
    hold(1'b0, BIT);
    hold(1'b1, 2 * BIT + BIT / 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_empty", int'(rx_empty), 1);
    chk("rst_full", int'(rx_full), 0);
    hold(1'b1, 2 * BIT);
    chk("rst_no_push", int'(rx_empty), 1);
    send(8'h7E, 1'b1, 1'b1);
    chk("post_rst_data", int'(rx_data), 8'h7E);
    chk("post_rst_empty", int'(rx_empty), 0);
    pop();
    chk("post_rst_pop", int'(rx_empty), 1);
    chk("total_perr", n_pe, 1);
    chk("total_ferr", n_fe, 2);
    chk("total_oerr", n_oe, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
